// File: rtl/cmd_mem_pkg.sv
// Shared definitions for the command-memory sender: error codes and ASCII framing bytes.
package cmd_mem_pkg;

   typedef enum logic [2:0] {
      NO_ERR    = 3'd0,
      ERR_SEL   = 3'd1,
      ERR_NO_LF = 3'd2
   } send_err_e;

   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] CR = 8'h0D;

endpackage

// File: rtl/cmd_sender.sv
// Streams one stored command from byte-wide command memory into a UART TX FIFO,
// stopping after the LF terminator or flagging an error on bad index / missing LF.
module cmd_sender
   import cmd_mem_pkg::*;
#(
   parameter  int CMD_WIDTH = 32,
   parameter  int CMD_DEPTH = 16,
   localparam int ADDR_W    = $clog2(CMD_WIDTH * CMD_DEPTH),
   localparam int SEL_W     = $clog2(CMD_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEL_W-1:0]  cmd_sel,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              tx_full,
   output logic              tx_wr_en,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        error_code,
   output logic              error_pulse
);

   localparam int IDX_W = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE, RD_COUNT, CHK_COUNT, FETCH, WAIT_BYTE, PUSH, DONE
   } state_e;

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        byte_q, byte_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   send_err_e         err_q, err_d;
   logic              errp_q, errp_d;

   // Address arithmetic is kept at ADDR_W bits; the top slot is never fetched.
   function automatic logic [ADDR_W-1:0] cmd_addr(input logic [SEL_W-1:0] s,
                                                  input logic [IDX_W-1:0] i);
      return ADDR_W'(s) * ADDR_W'(CMD_WIDTH) + ADDR_W'(1) + ADDR_W'(i);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         err_q   <= NO_ERR;
         errp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         errp_q  <= errp_d;
      end
   end

   // Read strobe/address are registered so they are presented during the
   // RD_COUNT and FETCH cycles; the TX strobe reacts to tx_full in the same cycle.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      idx_d    = idx_q;
      byte_d   = byte_q;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      err_d    = err_q;
      errp_d   = 1'b0;
      tx_wr_en = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = cmd_sel;
               idx_d   = '0;
               err_d   = NO_ERR;
               rd_en_d = 1'b1;
               addr_d  = '0;
               state_d = RD_COUNT;
            end
         end
         RD_COUNT: state_d = CHK_COUNT;
         CHK_COUNT: begin
            if (int'(sel_q) >= int'(mem_rdata) || int'(sel_q) >= CMD_DEPTH - 1) begin
               err_d   = ERR_SEL;
               errp_d  = 1'b1;
               state_d = IDLE;
            end else begin
               rd_en_d = 1'b1;
               addr_d  = cmd_addr(sel_q, idx_q);
               state_d = FETCH;
            end
         end
         FETCH: state_d = WAIT_BYTE;
         WAIT_BYTE: begin
            byte_d  = mem_rdata;
            state_d = PUSH;
         end
         PUSH: begin
            if (!tx_full) begin
               tx_wr_en = 1'b1;
               if (byte_q == LF) begin
                  state_d = DONE;
               end else if (idx_q == IDX_W'(CMD_WIDTH - 1)) begin
                  err_d   = ERR_NO_LF;
                  errp_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  rd_en_d = 1'b1;
                  addr_d  = cmd_addr(sel_q, idx_q + IDX_W'(1));
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_rd_en   = rd_en_q;
   assign mem_addr    = addr_q;
   assign tx_data     = byte_q;
   assign busy        = (state_q != IDLE);
   assign error_code  = err_q;
   assign error_pulse = errp_q;

endmodule
